// File: rtl/div32_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div32_pkg;

  localparam int DIV_W    = 32;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: s = a + b + ci, co = carry out of bit 31.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (32-bit addends), ci (carry in), s (32-bit sum), co (carry out).
module cla32
  import div32_pkg::*;
(
  input  logic [DIV_W-1:0] a,
  input  logic [DIV_W-1:0] b,
  input  logic             ci,
  output logic [DIV_W-1:0] s,
  output logic             co
);

  logic [DIV_W-1:0] g;
  logic [DIV_W-1:0] p;
  logic [DIV_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Eight 4-bit lookahead groups; the group carry-out is formed directly
  // from the group generate/propagate terms and chained into the next group.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int k = 0; k < DIV_W / 4; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  assign s  = p ^ c[DIV_W-1:0];
  assign co = c[DIV_W];

endmodule

// File: rtl/div32.sv
// Unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle.
// Latency: 33 cycles from accepted start to done (1 cycle for divide-by-zero).
// Backpressure: start is ignored while busy; accepted again in the done cycle.
// Ports: clk, reset (sync, active-high), start, dividend, divisor ->
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero.
module div32
  import div32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [CNT_W-1:0] count;
  // dvd shifts the dividend out of its MSB while quotient bits shift in at
  // the LSB, so after 32 steps it holds the full quotient.
  logic [DIV_W-1:0] dvd;
  logic [DIV_W-1:0] dsr;
  logic [DIV_W-1:0] rem;

  logic [DIV_W:0]   shifted;
  logic [DIV_W-1:0] diff;
  logic             carry;
  logic             succ;
  logic [DIV_W-1:0] next_rem;
  logic [DIV_W-1:0] next_dvd;

  assign shifted = {rem, dvd[DIV_W-1]};

  // shifted[31:0] - divisor as shifted[31:0] + ~divisor + 1.
  cla32 u_sub (
    .a  (shifted[DIV_W-1:0]),
    .b  (~dsr),
    .ci (1'b1),
    .s  (diff),
    .co (carry)
  );

  // A set bit 32 means shifted >= 2^32 > divisor, so the subtract always fits;
  // the low 32 bits of the difference are then still the correct remainder.
  assign succ     = shifted[DIV_W] | carry;
  assign next_rem = succ ? diff : shifted[DIV_W-1:0];
  assign next_dvd = {dvd[DIV_W-2:0], succ};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              dvd   <= dividend;
              dsr   <= divisor;
              rem   <= '0;
              count <= CNT_W'(DIV_ITER - 1);
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          dvd   <= next_dvd;
          rem   <= next_rem;
          count <= count - 1'b1;
          if (count == '0) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= next_dvd;
            remainder   <= next_rem;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
